// File: rtl/rtype_issue_unit_pkg.sv
// Shared definitions for the R-type issue/writeback stage: widths, opcodes, states, instruction layout.
package rtype_issue_unit_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [OP_W-1:0]    OP_RTYPE  = 6'd0;
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'd27;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'd28;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL = 6'd29;
  localparam logic [FUNCT_W-1:0] FUNCT_SLL = 6'd30;
  localparam logic [FUNCT_W-1:0] FUNCT_XOR = 6'd31;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Field order matches the instruction word, MSB first.
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [AW-1:0]      rs;
    logic [AW-1:0]      rt;
    logic [AW-1:0]      rd;
    logic [SHAMT_W-1:0] shamt;
    logic [FUNCT_W-1:0] funct;
  } instr_t;

  // An instruction is issued only for the R-type opcode with a supported funct.
  function automatic logic is_legal(input instr_t i);
    return (i.op == OP_RTYPE) &&
           (i.funct inside {FUNCT_ADD, FUNCT_SUB, FUNCT_SRL, FUNCT_SLL, FUNCT_XOR, FUNCT_AND});
  endfunction

endpackage

// File: rtl/rtype_issue_unit_if.sv
// Instruction handshake, ALU operand/result bus, status and debug register access.
interface rtype_issue_unit_if;
  import rtype_issue_unit_pkg::*;

  logic                instr_valid;
  logic                instr_ready;
  logic [XLEN-1:0]     instr;
  logic [XLEN-1:0]     alu_src1;
  logic [XLEN-1:0]     alu_src2;
  logic [FUNCT_W-1:0]  alu_funct;
  logic [SHAMT_W-1:0]  alu_shamt;
  logic [XLEN-1:0]     alu_result;
  logic                alu_zero;
  logic                alu_carry;
  logic                done;
  logic                illegal;
  logic                flag_zero;
  logic                flag_carry;
  logic                dbg_we;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_wdata;
  logic [XLEN-1:0]     dbg_rdata;

  modport slave (
    input  instr_valid, instr, alu_result, alu_zero, alu_carry, dbg_we, dbg_addr, dbg_wdata,
    output instr_ready, alu_src1, alu_src2, alu_funct, alu_shamt, done, illegal,
           flag_zero, flag_carry, dbg_rdata
  );

  modport master (
    output instr_valid, instr, alu_result, alu_zero, alu_carry, dbg_we, dbg_addr, dbg_wdata,
    input  instr_ready, alu_src1, alu_src2, alu_funct, alu_shamt, done, illegal,
           flag_zero, flag_carry, dbg_rdata
  );

endinterface

// File: rtl/rtype_issue_unit_regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one write port, R0 tied to zero.
module rtype_issue_unit_regfile
  import rtype_issue_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  input  logic [AW-1:0]   raddr3,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] rdata3,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  // Write path; address 0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
  assign rdata3 = (raddr3 == '0) ? '0 : regs_q[raddr3];

endmodule

// File: rtl/rtype_issue_unit.sv
// Four-cycle unpipelined issue/writeback stage around an external combinational ALU.
module rtype_issue_unit
  import rtype_issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rtype_issue_unit_if.slave bus
);

  state_e              state_q, state_d;
  instr_t              instr_q, instr_d;
  logic [XLEN-1:0]     src1_q, src1_d;
  logic [XLEN-1:0]     src2_q, src2_d;
  logic [FUNCT_W-1:0]  funct_q, funct_d;
  logic [SHAMT_W-1:0]  shamt_q, shamt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                res_zero_q, res_zero_d;
  logic                res_carry_q, res_carry_d;
  logic                flag_zero_q, flag_zero_d;
  logic                flag_carry_q, flag_carry_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  logic                rf_we;
  logic [AW-1:0]       rf_waddr;
  logic [XLEN-1:0]     rf_wdata;
  logic [XLEN-1:0]     rf_rdata1;
  logic [XLEN-1:0]     rf_rdata2;
  logic [XLEN-1:0]     rf_rdata_dbg;

  rtype_issue_unit_regfile u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instr_q.rs),
    .raddr2 (instr_q.rt),
    .raddr3 (bus.dbg_addr),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .rdata3 (rf_rdata_dbg),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  // Next-state, decode and write-port steering; debug writes and writeback never share an edge.
  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    funct_d      = funct_q;
    shamt_d      = shamt_q;
    result_d     = result_q;
    res_zero_d   = res_zero_q;
    res_carry_d  = res_carry_q;
    flag_zero_d  = flag_zero_q;
    flag_carry_d = flag_carry_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    rf_we        = 1'b0;
    rf_waddr     = bus.dbg_addr;
    rf_wdata     = bus.dbg_wdata;

    case (state_q)
      ST_IDLE: begin
        rf_we = bus.dbg_we;
        if (bus.instr_valid) begin
          instr_d = instr_t'(bus.instr);
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (is_legal(instr_q)) begin
          src1_d  = rf_rdata1;
          src2_d  = rf_rdata2;
          funct_d = instr_q.funct;
          shamt_d = instr_q.shamt;
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d    = bus.alu_result;
        res_zero_d  = bus.alu_zero;
        res_carry_d = bus.alu_carry;
        state_d     = ST_WB;
      end
      ST_WB: begin
        rf_we        = 1'b1;
        rf_waddr     = instr_q.rd;
        rf_wdata     = result_q;
        flag_zero_d  = res_zero_q;
        flag_carry_d = res_carry_q;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      src1_q       <= '0;
      src2_q       <= '0;
      funct_q      <= '0;
      shamt_q      <= '0;
      result_q     <= '0;
      res_zero_q   <= 1'b0;
      res_carry_q  <= 1'b0;
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      funct_q      <= funct_d;
      shamt_q      <= shamt_d;
      result_q     <= result_d;
      res_zero_q   <= res_zero_d;
      res_carry_q  <= res_carry_d;
      flag_zero_q  <= flag_zero_d;
      flag_carry_q <= flag_carry_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.alu_src1    = src1_q;
  assign bus.alu_src2    = src2_q;
  assign bus.alu_funct   = funct_q;
  assign bus.alu_shamt   = shamt_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.flag_zero   = flag_zero_q;
  assign bus.flag_carry  = flag_carry_q;
  assign bus.dbg_rdata   = rf_rdata_dbg;

endmodule

// File: tb/tb_rtype_issue_unit.sv
// Bench for rtype_issue_unit: directed cases plus randomized instructions against a register/flag model.
module tb_rtype_issue_unit;

  logic clk = 1'b0;
  logic rst_n;

  rtype_issue_unit_if bus ();

  rtype_issue_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Architectural model: register contents, sticky flags, last issued ALU operands.
  logic [31:0] m_reg [32];
  logic        m_fz, m_fc;
  logic [31:0] m_src1, m_src2;
  logic [5:0]  m_funct;
  logic [4:0]  m_shamt;

  // Behaviour of the ALU by mnemonic: {carry, result}; carry is a+b overflow or a<b borrow.
  function automatic logic [32:0] ref_alu(input logic [5:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (fn)
      6'd27:   return {1'b0, a} + {1'b0, b};
      6'd28:   return {(a < b), a - b};
      6'd29:   return {1'b0, a >> sh};
      6'd30:   return {1'b0, a << sh};
      6'd31:   return {1'b0, a ^ b};
      6'd32:   return {1'b0, a & b};
      default: return 33'd0;
    endcase
  endfunction

  // Combinational ALU attached to the DUT's operand bus.
  logic [32:0] alu_out;
  always_comb begin
    alu_out        = ref_alu(bus.alu_funct, bus.alu_src1, bus.alu_src2, bus.alu_shamt);
    bus.alu_result = alu_out[31:0];
    bus.alu_carry  = alu_out[32];
    bus.alu_zero   = (alu_out[31:0] == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_fz = 1'b0; m_fc = 1'b0;
    m_src1 = 32'd0; m_src2 = 32'd0; m_funct = 6'd0; m_shamt = 5'd0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #1;
      chk(tag, bus.dbg_rdata, m_reg[i]);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_fz"}, 32'(bus.flag_zero), 32'(m_fz));
    chk({tag, "_fc"}, 32'(bus.flag_carry), 32'(m_fc));
    chk({tag, "_src1"}, bus.alu_src1, m_src1);
    chk({tag, "_src2"}, bus.alu_src2, m_src2);
    chk({tag, "_funct"}, 32'(bus.alu_funct), 32'(m_funct));
    chk({tag, "_shamt"}, 32'(bus.alu_shamt), 32'(m_shamt));
  endtask

  task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
    bus.dbg_we = 1'b1; bus.dbg_addr = a; bus.dbg_wdata = d;
    tick();
    bus.dbg_we = 1'b0;
    if (a != 5'd0) m_reg[a] = d;
  endtask

  // Runs one instruction from accept to completion; optional debug write on the accepting
  // edge and optional ignored debug writes while busy.
  task automatic issue(input logic [31:0] iw, input logic dw_en, input logic [4:0] dw_a,
                       input logic [31:0] dw_d, input logic junk);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    logic       legal;
    logic [32:0] r;
    op = iw[31:26]; rs = iw[25:21]; rt = iw[20:16]; rd = iw[15:11]; sh = iw[10:6]; fn = iw[5:0];
    legal = (op == 6'd0) && (fn >= 6'd27) && (fn <= 6'd32);
    chk("ready_idle", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1; bus.instr = iw;
    bus.dbg_we = dw_en; bus.dbg_addr = dw_a; bus.dbg_wdata = dw_d;
    tick();  // accept
    if (dw_en && dw_a != 5'd0) m_reg[dw_a] = dw_d;
    bus.instr_valid = 1'b0; bus.instr = $urandom;
    bus.dbg_we = junk; bus.dbg_addr = 5'($urandom_range(0, 31)); bus.dbg_wdata = $urandom;
    chk("ready_busy", 32'(bus.instr_ready), 32'd0);
    tick();  // decode / operand read
    if (!legal) begin
      bus.dbg_we = 1'b0;
      chk("illegal_pulse", 32'(bus.illegal), 32'd1);
      chk("illegal_nodone", 32'(bus.done), 32'd0);
      check_status("illegal_hold");
      tick();
      chk("illegal_clear", 32'(bus.illegal), 32'd0);
      chk("illegal_ready", 32'(bus.instr_ready), 32'd1);
      chk("illegal_nodone2", 32'(bus.done), 32'd0);
      return;
    end
    m_src1 = m_reg[rs]; m_src2 = m_reg[rt]; m_funct = fn; m_shamt = sh;
    chk("read_noill", 32'(bus.illegal), 32'd0);
    check_status("read");
    tick();  // result capture
    chk("exec_nodone", 32'(bus.done), 32'd0);
    tick();  // writeback
    bus.dbg_we = 1'b0;
    r = ref_alu(fn, m_src1, m_src2, sh);
    if (rd != 5'd0) m_reg[rd] = r[31:0];
    m_fz = (r[31:0] == 32'd0); m_fc = r[32];
    chk("wb_done", 32'(bus.done), 32'd1);
    chk("wb_noill", 32'(bus.illegal), 32'd0);
    chk("wb_ready", 32'(bus.instr_ready), 32'd1);
    chk("wb_fz", 32'(bus.flag_zero), 32'(m_fz));
    chk("wb_fc", 32'(bus.flag_carry), 32'(m_fc));
    bus.dbg_addr = rd;
    #1;
    chk("wb_rd", bus.dbg_rdata, m_reg[rd]);
    tick();
    chk("done_clear", 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [31:0] iw;
    logic [5:0]  op, fn;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.instr = 32'd0;
    bus.dbg_we = 1'b0; bus.dbg_addr = 5'd0; bus.dbg_wdata = 32'd0;
    model_reset();
    #12;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    check_status("rst");
    check_regs("rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic sequence.
    dbg_write(5'd1, 32'hFFFF_FFFF);
    dbg_write(5'd2, 32'h0000_0001);
    dbg_write(5'd0, 32'hDEAD_BEEF);
    issue(32'h0022_181B, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("add_r3", m_reg[3], 32'd0);
    chk("add_flags", {30'd0, bus.flag_zero, bus.flag_carry}, 32'd3);
    issue(32'h0041_201C, 1'b0, 5'd0, 32'd0, 1'b0);
    issue(32'h0040_011E, 1'b0, 5'd0, 32'd0, 1'b0);
    issue(32'h0040_291E, 1'b0, 5'd0, 32'd0, 1'b0);
    check_regs("dir_reg");

    // Rejected instructions leave everything unchanged.
    issue(32'h0022_1805, 1'b0, 5'd0, 32'd0, 1'b0);
    issue(32'h2022_181B, 1'b0, 5'd0, 32'd0, 1'b0);
    check_regs("ill_reg");
    check_status("ill_after");

    // Debug write coincident with accept feeds the new value to the instruction.
    issue(32'h00E2_381F, 1'b1, 5'd7, 32'h1234_5678, 1'b1);

    // Reset while the instruction is in its result-capture cycle.
    bus.instr_valid = 1'b1; bus.instr = 32'h0022_301B;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ready", 32'(bus.instr_ready), 32'd1);
    bus.dbg_addr = 5'd6;
    #1;
    chk("abort_r6", bus.dbg_rdata, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("abort_nodone", 32'(bus.done), 32'd0);
    tick();
    chk("abort_nodone2", 32'(bus.done), 32'd0);
    check_status("abort");
    dbg_write(5'd1, 32'h8000_0000);
    dbg_write(5'd2, 32'h8000_0000);
    issue(32'h0022_301B, 1'b0, 5'd0, 32'd0, 1'b0);

    // Randomized instructions with register seeding and debug-port traffic.
    for (int i = 1; i < 32; i++) dbg_write(5'(i), $urandom);
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(27, 32));
      iw = {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn};
      if ($urandom_range(0, 4) == 0) dbg_write(5'($urandom_range(0, 31)), $urandom);
      issue(iw, 1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)));
    end
    check_regs("rand_reg");
    check_status("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
